// File: rtl/trdb_resync_counter.sv
// Resynchronisation timer for the trace encoder: counts cycles or emitted packets
// and holds a sync-packet request until the emitter acknowledges a sync packet.
module trdb_resync_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             trace_activated_i,
  input  logic             resync_enable_i,
  input  logic             resync_mode_i,
  input  logic [CNT_W-1:0] resync_max_i,
  input  logic             packet_emitted_i,
  input  logic             sync_packet_emitted_i,
  output logic             resync_o,
  output logic             resync_overdue_o,
  output logic [CNT_W-1:0] resync_cnt_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COUNTING = 2'd1;
  localparam logic [1:0] PENDING  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resync_q, resync_d;
  logic             overdue_q, overdue_d;

  logic             active;
  logic             count_en;
  logic [CNT_W:0]   cnt_inc;
  logic             expire;

  assign active   = trace_activated_i & resync_enable_i;
  assign count_en = (resync_mode_i | packet_emitted_i) & (resync_max_i != '0);
  // One extra bit so counter+1 cannot wrap before the compare against the period.
  assign cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign expire   = count_en & (cnt_inc >= {1'b0, resync_max_i});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    resync_d  = resync_q;
    overdue_d = overdue_q;
    if (!active) begin
      state_d   = IDLE;
      cnt_d     = '0;
      resync_d  = 1'b0;
      overdue_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COUNTING;
          cnt_d   = '0;
        end
        COUNTING: begin
          // A sync packet also pulses packet_emitted_i; the ack wins so it is not counted.
          if (sync_packet_emitted_i) begin
            cnt_d = '0;
          end else if (expire) begin
            cnt_d    = '0;
            state_d  = PENDING;
            resync_d = 1'b1;
          end else if (count_en) begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        PENDING: begin
          if (sync_packet_emitted_i) begin
            cnt_d     = '0;
            state_d   = COUNTING;
            resync_d  = 1'b0;
            overdue_d = 1'b0;
          end else if (expire) begin
            cnt_d     = '0;
            overdue_d = 1'b1;
          end else if (count_en) begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = '0;
          resync_d  = 1'b0;
          overdue_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      resync_q  <= 1'b0;
      overdue_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      resync_q  <= resync_d;
      overdue_q <= overdue_d;
    end
  end

  assign resync_o         = resync_q;
  assign resync_overdue_o = overdue_q;
  assign resync_cnt_o     = cnt_q;

endmodule

// File: tb/tb_trdb_resync_counter.sv
// Bench for trdb_resync_counter: per-cycle vector table, hand sequences for long
// and asynchronous corner cases, and a short randomly-spaced packet-mode run.
module tb_trdb_resync_counter;

  localparam int CW = 16;
  localparam int W  = CW + 2;

  logic          clk;
  logic          rst_n;
  logic          trace_act;
  logic          resync_en;
  logic          mode;
  logic [CW-1:0] max_v;
  logic          pkt;
  logic          sync;
  logic          resync;
  logic          overdue;
  logic [CW-1:0] cnt;

  logic [W-1:0]  exp_q[$];
  int            n_tests;
  int            n_fail;

  trdb_resync_counter #(.CNT_W(CW)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .trace_activated_i     (trace_act),
    .resync_enable_i       (resync_en),
    .resync_mode_i         (mode),
    .resync_max_i          (max_v),
    .packet_emitted_i      (pkt),
    .sync_packet_emitted_i (sync),
    .resync_o              (resync),
    .resync_overdue_o      (overdue),
    .resync_cnt_o          (cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, got no summary, required completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic          tr;
    logic          en;
    logic          md;
    logic [CW-1:0] mx;
    logic          pk;
    logic          sy;
    logic          r;
    logic          o;
    logic [CW-1:0] c;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic tr, logic en, logic md, logic [CW-1:0] mx, logic pk,
                              logic sy, logic r, logic o, logic [CW-1:0] c);
    vec_t v;
    v.tr = tr; v.en = en; v.md = md; v.mx = mx; v.pk = pk; v.sy = sy;
    v.r = r; v.o = o; v.c = c;
    return v;
  endfunction

  task automatic check_now(input logic [W-1:0] exp, input string name);
    logic [W-1:0] act;
    act = {resync, overdue, cnt};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got resync=%b overdue=%b cnt=%0d, required resync=%b overdue=%b cnt=%0d",
               name, act[W-1], act[W-2], act[CW-1:0], exp[W-1], exp[W-2], exp[CW-1:0]);
    end
  endtask

  // driver: one cycle of inputs, expectation queued, checked after the edge
  task automatic step(input logic tr, input logic en, input logic md, input logic [CW-1:0] mx,
                      input logic pk, input logic sy, input logic r, input logic o,
                      input logic [CW-1:0] c, input string name);
    logic [W-1:0] e;
    @(negedge clk);
    trace_act = tr; resync_en = en; mode = md; max_v = mx; pkt = pk; sync = sy;
    exp_q.push_back({r, o, c});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got cnt=%0d, required one queued entry", name, cnt);
    end else begin
      e = exp_q.pop_front();
      check_now(e, name);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; trace_act = 1'b0; resync_en = 1'b0; mode = 1'b0;
    max_v = '0; pkt = 1'b0; sync = 1'b0;
    #1;
    check_now('0, "reset_state");

    // 1: cycle mode, max 4, ack three cycles into PENDING
    vecs.push_back(mk(1,1,1,4,0,0, 0,0,0));
    vecs.push_back(mk(1,1,1,4,0,0, 0,0,1));
    vecs.push_back(mk(1,1,1,4,0,0, 0,0,2));
    vecs.push_back(mk(1,1,1,4,0,0, 0,0,3));
    vecs.push_back(mk(1,1,1,4,0,0, 1,0,0));
    vecs.push_back(mk(1,1,1,4,0,0, 1,0,1));
    vecs.push_back(mk(1,1,1,4,0,0, 1,0,2));
    vecs.push_back(mk(1,1,1,4,0,1, 0,0,0));
    vecs.push_back(mk(1,1,1,4,0,0, 0,0,1));
    // 2: packet mode, max 3, five pulses then a sync packet
    vecs.push_back(mk(0,1,0,3,0,0, 0,0,0));
    vecs.push_back(mk(1,1,0,3,0,0, 0,0,0));
    vecs.push_back(mk(1,1,0,3,1,0, 0,0,1));
    vecs.push_back(mk(1,1,0,3,0,0, 0,0,1));
    vecs.push_back(mk(1,1,0,3,1,0, 0,0,2));
    vecs.push_back(mk(1,1,0,3,0,0, 0,0,2));
    vecs.push_back(mk(1,1,0,3,1,0, 1,0,0));
    vecs.push_back(mk(1,1,0,3,0,0, 1,0,0));
    vecs.push_back(mk(1,1,0,3,1,0, 1,0,1));
    vecs.push_back(mk(1,1,0,3,0,0, 1,0,1));
    vecs.push_back(mk(1,1,0,3,1,0, 1,0,2));
    vecs.push_back(mk(1,1,0,3,1,1, 0,0,0));
    vecs.push_back(mk(1,1,0,3,0,0, 0,0,0));
    // 3: overdue, cycle mode, max 2, no ack until overdue
    vecs.push_back(mk(1,1,1,2,0,0, 0,0,1));
    vecs.push_back(mk(1,1,1,2,0,0, 1,0,0));
    vecs.push_back(mk(1,1,1,2,0,0, 1,0,1));
    vecs.push_back(mk(1,1,1,2,0,0, 1,1,0));
    vecs.push_back(mk(1,1,1,2,0,0, 1,1,1));
    vecs.push_back(mk(1,1,1,2,0,1, 0,0,0));
    // 5: live period change 10 -> 3 at cnt 6
    vecs.push_back(mk(1,0,1,10,0,0, 0,0,0));
    vecs.push_back(mk(1,1,1,10,0,0, 0,0,0));
    for (int i = 1; i <= 6; i++) vecs.push_back(mk(1,1,1,10,0,0, 0,0,CW'(i)));
    vecs.push_back(mk(1,1,1,3,0,0, 1,0,0));
    vecs.push_back(mk(1,1,1,3,0,0, 1,0,1));
    // 6a: trace dropped while PENDING, then reactivation starts with no count
    vecs.push_back(mk(0,1,1,3,0,0, 0,0,0));
    vecs.push_back(mk(1,1,1,3,0,0, 0,0,0));
    // max 1: expiry on every event, second one is overdue
    vecs.push_back(mk(1,1,1,1,0,0, 1,0,0));
    vecs.push_back(mk(1,1,1,1,0,0, 1,1,0));

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].tr, vecs[i].en, vecs[i].md, vecs[i].mx, vecs[i].pk, vecs[i].sy,
           vecs[i].r, vecs[i].o, vecs[i].c, $sformatf("vec%0d", i));
    end

    // 4: period 0 never expires, then period 5
    step(0,1,1,0,0,0, 0,0,0, "max0_deact");
    step(1,1,1,0,0,0, 0,0,0, "max0_start");
    for (int i = 0; i < 100; i++) step(1,1,1,0,0,0, 0,0,0, "max0_hold");
    for (int i = 1; i <= 4; i++) step(1,1,1,5,0,0, 0,0,CW'(i), "max5_count");
    step(1,1,1,5,0,0, 1,0,0, "max5_expire");

    // 6b: asynchronous reset between edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_now('0, "async_reset");
    @(posedge clk);
    #1;
    check_now('0, "reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    step(1,1,0,3,0,0, 0,0,0, "post_reset_start");

    // packet mode, max 3, randomly spaced pulses
    for (int k = 1; k <= 6; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        step(1,1,0,3,0,0, (k > 3), 1'b0, CW'((k - 1) % 3), "rand_gap");
      step(1,1,0,3,1,0, (k >= 3), (k >= 6), CW'(k % 3), "rand_pulse");
    end

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
